// File: rtl/dma_ctrl.sv
// Word-granular memory-to-memory DMA engine: a bus master moves SRC->DST one word at a time
// (one read, then one write), programmed via a 4-register bus slave with a level completion irq.
module dma_ctrl #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_cs_,
    input  logic              s_as_,
    input  logic              s_rw,
    input  logic [1:0]        s_addr,
    input  logic [DATA_W-1:0] s_wr_data,
    output logic [DATA_W-1:0] s_rd_data,
    output logic              s_rdy_,
    output logic              m_req_,
    input  logic              m_grnt_,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_as_,
    output logic              m_rw,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_rdy_,
    output logic              irq,
    output logic [2:0]        dbg_state
);

    localparam logic       READ     = 1'b1;
    localparam logic       WRITE    = 1'b0;
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_SRC  = 2'd1;
    localparam logic [1:0] REG_DST  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_WR,
        ST_NEXT,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                ie_q, ie_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic [DATA_W-1:0]   s_rd_data_q, s_rd_data_d;
    logic                s_rdy_q, s_rdy_d;
    logic                m_req_q, m_req_d;
    logic                m_as_q, m_as_d;
    logic                m_rw_q, m_rw_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wr_data_q, m_wr_data_d;

    logic                busy;
    logic                slv_acc;
    logic                slv_wr;
    logic                start_req;
    logic                abort_wr;
    logic                done_set;
    logic [DATA_W-1:0]   rd_mux;
    logic                unused_wr_bits;

    // Only the low bits of the write data reach any register.
    assign unused_wr_bits = ^s_wr_data;

    always_comb begin
        busy        = (state_q != ST_IDLE);
        slv_acc     = !s_cs_ && !s_as_;
        slv_wr      = slv_acc && !s_rw;
        start_req   = 1'b0;
        abort_wr    = 1'b0;
        done_set    = 1'b0;
        rd_mux      = '0;

        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        ie_d        = ie_q;
        done_d      = done_q;
        abort_d     = abort_q;
        s_rdy_d     = 1'b1;
        s_rd_data_d = '0;
        m_req_d     = m_req_q;
        m_as_d      = m_as_q;
        m_rw_d      = m_rw_q;
        m_addr_d    = m_addr_q;
        m_wr_data_d = m_wr_data_q;

        case (s_addr)
            REG_CTRL: begin
                rd_mux[2] = ie_q;
                rd_mux[1] = done_q;
                rd_mux[0] = busy;
            end
            REG_SRC: rd_mux = DATA_W'(src_q);
            REG_DST: rd_mux = DATA_W'(dst_q);
            default: rd_mux = DATA_W'(len_q);
        endcase

        if (slv_acc) begin
            s_rdy_d = 1'b0;
            if (s_rw) begin
                s_rd_data_d = rd_mux;
            end
        end

        // Address/length registers are frozen while a transfer owns them.
        if (slv_wr) begin
            case (s_addr)
                REG_CTRL: begin
                    ie_d = s_wr_data[2];
                    if (s_wr_data[1]) begin
                        done_d = 1'b0;
                    end
                    abort_wr  = s_wr_data[3] && busy;
                    start_req = s_wr_data[0] && !busy;
                end
                REG_SRC: if (!busy) src_d = s_wr_data[ADDR_W-1:0];
                REG_DST: if (!busy) dst_d = s_wr_data[ADDR_W-1:0];
                default: if (!busy) len_d = s_wr_data[LEN_W-1:0];
            endcase
        end

        if (abort_wr) begin
            abort_d = 1'b1;
        end

        // Bus outputs are registered, so they are set on the transition into each state.
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    if (len_q == '0) begin
                        done_set = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        m_req_d = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                if (!m_grnt_) begin
                    state_d  = ST_RD;
                    m_as_d   = 1'b0;
                    m_rw_d   = READ;
                    m_addr_d = src_q;
                end
            end
            ST_RD: begin
                if (!m_rdy_) begin
                    state_d     = ST_WR;
                    m_rw_d      = WRITE;
                    m_addr_d    = dst_q;
                    m_wr_data_d = m_rd_data;
                end
            end
            ST_WR: begin
                if (!m_rdy_) begin
                    state_d = ST_NEXT;
                    m_req_d = 1'b1;
                    m_as_d  = 1'b1;
                    m_rw_d  = READ;
                end
            end
            ST_NEXT: begin
                src_d = src_q + ADDR_W'(1);
                dst_d = dst_q + ADDR_W'(1);
                len_d = len_q - LEN_W'(1);
                if (len_q == LEN_W'(1) || abort_q || abort_wr) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                    m_req_d = 1'b0;
                end
            end
            ST_DONE: begin
                done_set = 1'b1;
                abort_d  = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A completion in the same cycle as a CPU clear must not be lost.
        if (done_set) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            ie_q        <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            s_rd_data_q <= '0;
            s_rdy_q     <= 1'b1;
            m_req_q     <= 1'b1;
            m_as_q      <= 1'b1;
            m_rw_q      <= READ;
            m_addr_q    <= '0;
            m_wr_data_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            ie_q        <= ie_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            s_rd_data_q <= s_rd_data_d;
            s_rdy_q     <= s_rdy_d;
            m_req_q     <= m_req_d;
            m_as_q      <= m_as_d;
            m_rw_q      <= m_rw_d;
            m_addr_q    <= m_addr_d;
            m_wr_data_q <= m_wr_data_d;
        end
    end

    assign s_rd_data = s_rd_data_q;
    assign s_rdy_    = s_rdy_q;
    assign m_req_    = m_req_q;
    assign m_as_     = m_as_q;
    assign m_rw      = m_rw_q;
    assign m_addr    = m_addr_q;
    assign m_wr_data = m_wr_data_q;
    assign irq       = done_q & ie_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: directed and random transfers against a word-copy reference model,
// with a bus responder that adds programmable grant/ready latency.
module tb_dma_ctrl;

    logic        clk;
    logic        reset;
    logic        s_cs_;
    logic        s_as_;
    logic        s_rw;
    logic [1:0]  s_addr;
    logic [31:0] s_wr_data;
    logic [31:0] s_rd_data;
    logic        s_rdy_;
    logic        m_req_;
    logic        m_grnt_;
    logic [29:0] m_addr;
    logic        m_as_;
    logic        m_rw;
    logic [31:0] m_wr_data;
    logic [31:0] m_rd_data;
    logic        m_rdy_;
    logic        irq;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Bus-side model state
    logic [31:0] mem [logic [29:0]];
    int          gnt_dly = 0;
    int          rdy_dly = 0;
    int          gcnt;
    int          rcnt;
    bit          in_xfer;
    logic [29:0] xfer_addr;
    logic        xfer_rw;
    logic        prev_req;
    int          stab_err = 0;
    int          req_sessions = 0;
    logic [29:0] rd_addr_q[$];
    logic [29:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    dma_ctrl #(.ADDR_W(30), .DATA_W(32), .LEN_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_cs_     (s_cs_),
        .s_as_     (s_as_),
        .s_rw      (s_rw),
        .s_addr    (s_addr),
        .s_wr_data (s_wr_data),
        .s_rd_data (s_rd_data),
        .s_rdy_    (s_rdy_),
        .m_req_    (m_req_),
        .m_grnt_   (m_grnt_),
        .m_addr    (m_addr),
        .m_as_     (m_as_),
        .m_rw      (m_rw),
        .m_wr_data (m_wr_data),
        .m_rd_data (m_rd_data),
        .m_rdy_    (m_rdy_),
        .irq       (irq),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bus responder: grant after gnt_dly cycles of request, ready after rdy_dly wait cycles.
    initial begin
        m_grnt_   = 1'b1;
        m_rdy_    = 1'b1;
        m_rd_data = '0;
        prev_req  = 1'b1;
        in_xfer   = 1'b0;
        gcnt      = 0;
        rcnt      = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                gcnt     = 0;
                rcnt     = 0;
                in_xfer  = 1'b0;
                m_grnt_  = 1'b1;
                m_rdy_   = 1'b1;
                prev_req = 1'b1;
            end else begin
                if (prev_req && !m_req_) req_sessions++;
                prev_req = m_req_;
                if (!m_req_) begin
                    if (gcnt >= gnt_dly) m_grnt_ = 1'b0;
                    else begin
                        gcnt++;
                        m_grnt_ = 1'b1;
                    end
                end else begin
                    gcnt    = 0;
                    m_grnt_ = 1'b1;
                end
                m_rdy_ = 1'b1;
                if (!m_as_) begin
                    if (!in_xfer) begin
                        in_xfer   = 1'b1;
                        xfer_addr = m_addr;
                        xfer_rw   = m_rw;
                        rcnt      = 0;
                    end else if (m_addr !== xfer_addr || m_rw !== xfer_rw) begin
                        stab_err++;
                    end
                    if (rcnt >= rdy_dly) begin
                        m_rdy_  = 1'b0;
                        in_xfer = 1'b0;
                        if (m_rw) begin
                            rd_addr_q.push_back(m_addr);
                            m_rd_data = mem.exists(m_addr) ? mem[m_addr] : (32'hDEAD0000 ^ {2'b00, m_addr});
                        end else begin
                            wr_addr_q.push_back(m_addr);
                            wr_data_q.push_back(m_wr_data);
                            mem[m_addr] = m_wr_data;
                        end
                    end else begin
                        rcnt++;
                    end
                end else if (in_xfer) begin
                    stab_err++;
                    in_xfer = 1'b0;
                end
            end
        end
    end

    // Driver tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        s_cs_     = 1'b0;
        s_as_     = 1'b0;
        s_rw      = 1'b0;
        s_addr    = a;
        s_wr_data = d;
        step();
        s_cs_ = 1'b1;
        s_as_ = 1'b1;
        s_rw  = 1'b1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        s_cs_  = 1'b0;
        s_as_  = 1'b0;
        s_rw   = 1'b1;
        s_addr = a;
        step();
        check("s_rdy_ on read", {31'b0, s_rdy_}, 32'h0);
        d     = s_rd_data;
        s_cs_ = 1'b1;
        s_as_ = 1'b1;
    endtask

    task automatic wait_irq(input int max, input string tag);
        int n = 0;
        while (irq !== 1'b1 && n < max) begin
            step();
            n++;
        end
        check(tag, {31'b0, irq}, 32'h1);
    endtask

    task automatic clear_obs();
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        req_sessions = 0;
        stab_err     = 0;
    endtask

    // Reference model: word i is read from src+i and written to dst+i (mod 2^30) with src's data.
    task automatic load_src(input logic [29:0] src, input int len, inout logic [31:0] exp_q[$]);
        logic [31:0] v;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            v = $urandom;
            mem[src + 30'(i)] = v;
            exp_q.push_back(v);
        end
    endtask

    task automatic score(input string tag, input logic [29:0] src, input logic [29:0] dst,
                         input int n, input logic [31:0] exp_q[$]);
        int m;
        check({tag, " read count"}, 32'(rd_addr_q.size()), 32'(n));
        check({tag, " write count"}, 32'(wr_addr_q.size()), 32'(n));
        m = (wr_addr_q.size() < n) ? wr_addr_q.size() : n;
        if (rd_addr_q.size() < m) m = rd_addr_q.size();
        for (int i = 0; i < m; i++) begin
            check({tag, " read addr"}, {2'b0, rd_addr_q[i]}, {2'b0, src + 30'(i)});
            check({tag, " write addr"}, {2'b0, wr_addr_q[i]}, {2'b0, dst + 30'(i)});
            check({tag, " write data"}, wr_data_q[i], exp_q[i]);
            check({tag, " dst mem"}, mem[dst + 30'(i)], exp_q[i]);
        end
        check({tag, " req per word"}, 32'(req_sessions), 32'(n));
        check({tag, " strobe/addr stable"}, 32'(stab_err), 32'h0);
    endtask

    task automatic run_xfer(input string tag, input logic [29:0] src, input logic [29:0] dst,
                            input int len, input int gd, input int rd);
        logic [31:0] exp_q[$];
        logic [31:0] r;
        gnt_dly = gd;
        rdy_dly = rd;
        load_src(src, len, exp_q);
        clear_obs();
        cpu_write(2'd1, {2'b0, src});
        cpu_write(2'd2, {2'b0, dst});
        cpu_write(2'd3, 32'(len));
        cpu_write(2'd0, 32'h5);
        wait_irq(4000, {tag, " irq"});
        score(tag, src, dst, len, exp_q);
        cpu_read(2'd3, r);
        check({tag, " LEN"}, r, 32'h0);
        cpu_read(2'd1, r);
        check({tag, " SRC"}, r, {2'b0, src + 30'(len)});
        cpu_read(2'd2, r);
        check({tag, " DST"}, r, {2'b0, dst + 30'(len)});
        cpu_read(2'd0, r);
        check({tag, " CTRL"}, r, 32'h6);
        cpu_write(2'd0, 32'h6);
        check({tag, " irq cleared"}, {31'b0, irq}, 32'h0);
    endtask

    // Main sequence
    initial begin
        logic [31:0] r;
        logic [31:0] exp_q[$];
        logic [29:0] src;
        int          n;

        reset     = 1'b0;
        s_cs_     = 1'b1;
        s_as_     = 1'b1;
        s_rw      = 1'b1;
        s_addr    = 2'd0;
        s_wr_data = '0;
        repeat (3) @(negedge clk);
        check("reset s_rd_data", s_rd_data, 32'h0);
        check("reset s_rdy_", {31'b0, s_rdy_}, 32'h1);
        check("reset m_req_", {31'b0, m_req_}, 32'h1);
        check("reset m_as_", {31'b0, m_as_}, 32'h1);
        check("reset m_rw", {31'b0, m_rw}, 32'h1);
        check("reset m_addr", {2'b0, m_addr}, 32'h0);
        check("reset m_wr_data", m_wr_data, 32'h0);
        check("reset irq", {31'b0, irq}, 32'h0);
        reset = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            cpu_read(2'(i), r);
            check("reset reg value", r, 32'h0);
        end
        step();
        check("idle s_rdy_", {31'b0, s_rdy_}, 32'h1);
        check("idle s_rd_data", s_rd_data, 32'h0);

        run_xfer("basic", 30'h100, 30'h200, 4, 0, 0);
        run_xfer("waits", 30'h100, 30'h200, 4, 5, 3);

        // Zero-length start: immediate DONE, no bus request
        clear_obs();
        cpu_write(2'd3, 32'h0);
        cpu_write(2'd0, 32'h5);
        check("len0 irq", {31'b0, irq}, 32'h1);
        cpu_read(2'd0, r);
        check("len0 CTRL", r, 32'h6);
        repeat (5) step();
        check("len0 no req", 32'(req_sessions), 32'h0);
        cpu_write(2'd0, 32'h6);
        check("len0 W1C irq", {31'b0, irq}, 32'h0);
        cpu_write(2'd0, 32'h5);
        check("len0 irq again", {31'b0, irq}, 32'h1);
        cpu_write(2'd0, 32'h0);
        check("IE clear irq", {31'b0, irq}, 32'h0);
        cpu_read(2'd0, r);
        check("IE clear keeps DONE", r, 32'h2);
        cpu_write(2'd0, 32'h6);

        run_xfer("wrap", 30'h3FFFFFFF, 30'h500, 2, 1, 1);
        check("wrap second read", {2'b0, rd_addr_q[1]}, 32'h0);

        // Abort after the 2nd write; busy-time register writes must be ignored
        gnt_dly = 2;
        rdy_dly = 2;
        load_src(30'h1000, 8, exp_q);
        clear_obs();
        cpu_write(2'd1, 32'h1000);
        cpu_write(2'd2, 32'h2000);
        cpu_write(2'd3, 32'h8);
        cpu_write(2'd0, 32'h5);
        n = 0;
        while (wr_addr_q.size() < 2 && n < 2000) begin
            step();
            n++;
        end
        check("abort 2nd write seen", 32'(wr_addr_q.size()), 32'h2);
        step();
        step();
        cpu_write(2'd0, 32'hC);
        cpu_write(2'd3, 32'h55);
        cpu_write(2'd1, 32'h777);
        cpu_write(2'd0, 32'h5);
        wait_irq(4000, "abort irq");
        score("abort", 30'h1000, 30'h2000, 3, exp_q);
        cpu_read(2'd3, r);
        check("abort LEN", r, 32'h5);
        cpu_read(2'd1, r);
        check("abort SRC", r, 32'h1003);
        cpu_read(2'd0, r);
        check("abort CTRL", r, 32'h6);
        repeat (5) step();
        check("abort no restart", 32'(wr_addr_q.size()), 32'h3);
        cpu_write(2'd0, 32'h6);

        for (int k = 0; k < 4; k++) begin
            src = 30'($urandom);
            run_xfer("random", src, src + 30'h10000, $urandom_range(1, 6),
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset asserted while a write is outstanding
        gnt_dly = 0;
        rdy_dly = 6;
        load_src(30'h40, 3, exp_q);
        clear_obs();
        cpu_write(2'd1, 32'h40);
        cpu_write(2'd2, 32'h80);
        cpu_write(2'd3, 32'h3);
        cpu_write(2'd0, 32'h5);
        n = 0;
        while (!(m_as_ === 1'b0 && m_rw === 1'b0) && n < 2000) begin
            step();
            n++;
        end
        check("reset-in-WR reached", {30'b0, m_as_, m_rw}, 32'h0);
        reset = 1'b0;
        #1;
        check("reset-in-WR m_as_", {31'b0, m_as_}, 32'h1);
        check("reset-in-WR m_req_", {31'b0, m_req_}, 32'h1);
        check("reset-in-WR irq", {31'b0, irq}, 32'h0);
        step();
        step();
        reset = 1'b1;
        step();
        req_sessions = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_read(2'(i), r);
            check("post-reset reg", r, 32'h0);
        end
        repeat (10) step();
        check("post-reset no bus req", 32'(req_sessions), 32'h0);
        check("post-reset m_as_", {31'b0, m_as_}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
